qspi_psram_write: RTL and testbench
===================================

// Module: qspi_psram_write
// PURPOSE
//  Streams bytes from the design into a QSPI PSRAM using quad write (cmd 8'h38: cmd on IO0, addr+data quad, SDR, no dummy).
//  Write-side counterpart to the QSPI flash read path; shares its pin style (spi_clk toggles every clk, optional half-cycle delay).
//  Accepts bytes via valid/ready; stalls the SPI clock low when no byte is available. Max rate one byte per 4 clk cycles.
// PARAMETERS
//  ADDR_BITS  24     address width; must be a multiple of 4 (ADDR_BITS/4 address nibbles)
//  WRITE_CMD  8'h38  command byte, sent MSB first on IO0
// PORTS
//  clk              in   1          system clock; all logic on posedge except spi_clk_n (negedge)
//  rstn             in   1          reset, synchronous, active low
//  spi_data_out     out  4          IO[3:0] drive value
//  spi_data_oe      out  4          IO[3:0] output enables
//  spi_select       out  1          chip select, active low (1 = deselected)
//  spi_clk_out      out  1          SPI clock to pad
//  use_neg_spi_clk  in   1          1: spi_clk_out delayed by half clk (negedge-registered copy)
//  addr_in          in   ADDR_BITS  start address, sampled with start_write
//  start_write      in   1          1-cycle pulse in IDLE starts a transaction
//  stop_write       in   1          1-cycle pulse ends transaction immediately
//  data_in          in   8          write byte
//  data_valid       in   1          data_in valid
//  data_ready       out  1          byte accepted when data_valid && data_ready
//  stalled          out  1          1 while in DATA waiting for a byte (SPI clock held low)
// BEHAVIOUR
//  Reset: IDLE, spi_select=1, spi_clk=0, spi_data_oe=0, spi_data_out=0, data_ready=0, stalled=0, buffer empty.
//  States: IDLE -> CMD (8 bits) -> ADDR (ADDR_BITS/4 nibbles) -> DATA (2 nibbles/byte, repeats until stop).
//  spi_select = (state==IDLE). spi_clk toggles every cycle outside IDLE, except held 0 while stalled.
//  Outputs change only with spi_clk low; PSRAM samples on rising edge. Bit/nibble counter advances on cycle where spi_clk==1.
//  IDLE + start_write: latch addr, state<=CMD, oe<=4'b0001, counter<=7. Cycle after start = cycle 1.
//  CMD: spi_data_out={3'b000, WRITE_CMD[cnt]}; bit7 at cycle 1, bit0 at cycle 15.
//  CMD->ADDR on spi_clk==1 with cnt==0: oe<=4'b1111; spi_data_out=addr top nibble, addr shifts left 4 each nibble.
//  ADDR->DATA after last nibble: for ADDR_BITS=24 first data nibble at cycle 29 if a byte is buffered.
//  DATA: high nibble then low nibble; byte k (no stalls) high nibble at cycle 29+4k.
//  Buffer: one-entry holding reg + shift reg. data_ready = (state!=IDLE) && !buf_full; preload during CMD/ADDR allowed.
//  At each byte boundary (entry to DATA, or spi_clk==1 on low nibble): buf_full -> load shift reg, clear buf_full;
//   else stalled=1, spi_clk stays 0, outputs hold; load and resume toggling the cycle after buf_full goes 1.
//  stop_write (any state, wins over start_write and data handshake): next cycle IDLE, spi_select=1, spi_clk=0,
//   oe=0, buffer cleared; a partial byte is dropped. stop_write in IDLE: no effect.
//  start_write outside IDLE ignored. data_valid without data_ready: no effect, data_in ignored.
//  Reset mid-transaction: same result as stop_write plus all counters/buffer cleared.
//  No address wrap handling; PSRAM page/CS-low limits are the caller's responsibility (use stop_write).
// TESTING
//  1. Hold rstn=0 2 cycles -> spi_select=1, spi_clk_out=0, oe=0, data_ready=0, stalled=0.
//  2. start_write addr=0x123456, bytes A5,3C preloaded -> IO0 00111000 cycles 1-15 odd; nibbles 1..6 cycles 17-27 odd; A,5,3,C at 29,31,33,35; oe 0001 then 1111.
//  3. Second byte valid 10 cycles late -> stalled=1, spi_clk_out stuck 0, no edges; resumes one cycle after accept, nibbles correct.
//  4. stop_write at cycle 20 (mid-address) -> cycle 21 spi_select=1, oe=0, data_ready=0; new start_write runs full sequence correctly.
//  5. use_neg_spi_clk=1 -> spi_clk_out edges half a clk later than with 0; data timing unchanged.
//  6. start_write during DATA ignored; stop_write+start_write same cycle in DATA -> IDLE, no new transaction.

Source files
------------

// File: rtl/qspi_psram_write.sv
// qspi_psram_write: quad-mode PSRAM writer (cmd on IO0, addr+data on IO[3:0]) fed through a one-byte valid/ready buffer
module qspi_psram_write #(
   parameter int ADDR_BITS = 24,
   parameter logic [7:0] WRITE_CMD = 8'h38
) (
   input  logic                 clk,
   input  logic                 rstn,
   output logic [3:0]           spi_data_out,
   output logic [3:0]           spi_data_oe,
   output logic                 spi_select,
   output logic                 spi_clk_out,
   input  logic                 use_neg_spi_clk,
   input  logic [ADDR_BITS-1:0] addr_in,
   input  logic                 start_write,
   input  logic                 stop_write,
   input  logic [7:0]           data_in,
   input  logic                 data_valid,
   output logic                 data_ready,
   output logic                 stalled
);
   localparam int NIB = ADDR_BITS / 4;
   localparam int CW = $clog2(NIB > 8 ? NIB : 8);
   typedef enum logic [1:0] {IDLE, CMD, ADDR, DATA} state_t;
   state_t state;
   logic [CW-1:0] cnt;
   logic [7:0] cmd_sh, buf_q;
   logic [3:0] low_q;
   logic [ADDR_BITS-1:0] addr_sh;
   logic buf_full, sclk, sclk_n, low_nib, accept, edge_b;
   assign data_ready = (state != IDLE) && !buf_full;
   assign accept = data_valid && data_ready;
   assign spi_select = (state == IDLE);
   assign spi_clk_out = use_neg_spi_clk ? sclk_n : sclk;
   assign edge_b = sclk && ((state == ADDR && cnt == '0) || (state == DATA && low_nib));
   always_ff @(posedge clk) begin
      if (!rstn || stop_write) begin
         state <= IDLE;
         cnt <= '0;
         cmd_sh <= '0;
         addr_sh <= '0;
         buf_q <= '0;
         low_q <= '0;
         buf_full <= 1'b0;
         sclk <= 1'b0;
         low_nib <= 1'b0;
         stalled <= 1'b0;
         spi_data_out <= '0;
         spi_data_oe <= '0;
      end else begin
         if (accept) begin
            buf_q <= data_in;
            buf_full <= 1'b1;
         end
         sclk <= (state != IDLE) && !stalled && !sclk;
         unique case (state)
            IDLE: if (start_write) begin
               state <= CMD;
               cnt <= CW'(7);
               cmd_sh <= WRITE_CMD << 1;
               addr_sh <= addr_in;
               spi_data_oe <= 4'b0001;
               spi_data_out <= {3'b000, WRITE_CMD[7]};
            end
            CMD: if (sclk) begin
               if (cnt == '0) begin
                  state <= ADDR;
                  cnt <= CW'(NIB - 1);
                  spi_data_oe <= 4'b1111;
                  spi_data_out <= addr_sh[ADDR_BITS-1 -: 4];
                  addr_sh <= addr_sh << 4;
               end else begin
                  cnt <= cnt - 1'b1;
                  spi_data_out <= {3'b000, cmd_sh[7]};
                  cmd_sh <= cmd_sh << 1;
               end
            end
            ADDR: if (sclk) begin
               if (cnt == '0) begin
                  state <= DATA;
               end else begin
                  cnt <= cnt - 1'b1;
                  spi_data_out <= addr_sh[ADDR_BITS-1 -: 4];
                  addr_sh <= addr_sh << 4;
               end
            end
            DATA: if (sclk && !low_nib) begin
               low_nib <= 1'b1;
               spi_data_out <= low_q;
            end
         endcase
         if (buf_full && (stalled || edge_b)) begin
            low_q <= buf_q[3:0];
            buf_full <= 1'b0;
            stalled <= 1'b0;
            low_nib <= 1'b0;
            spi_data_out <= buf_q[7:4];
         end else if (edge_b) begin
            stalled <= 1'b1;
         end
      end
   end
   always_ff @(negedge clk) begin
      if (!rstn) sclk_n <= 1'b0;
      else sclk_n <= sclk;
   end
endmodule

// File: tb/tb_qspi_psram_write.sv
// tb_qspi_psram_write: randomized bench checking pin timing and the PSRAM-visible nibble stream against a reference model
module tb_qspi_psram_write;
   localparam int AB = 24;
   localparam int NIB = AB / 4;
   localparam logic [7:0] CMD = 8'h38;
   logic clk = 1'b0, rstn = 1'b0;
   logic [3:0] spi_data_out, spi_data_oe;
   logic spi_select, spi_clk_out;
   logic use_neg_spi_clk = 1'b0;
   logic [AB-1:0] addr_in = '0;
   logic start_write = 1'b0, stop_write = 1'b0;
   logic [7:0] data_in = '0;
   logic data_valid = 1'b0;
   logic data_ready, stalled;
   int n_tests = 0, n_fail = 0;
   int cyc = 0, wt = 0, rs = -10;
   logic [7:0] rb = '0;
   logic prev_clk = 1'b0;
   logic [7:0] bq[$];
   int gq[$];
   int acc[$];
   logic [7:0] cap[$];
   qspi_psram_write #(.ADDR_BITS(AB), .WRITE_CMD(CMD)) dut (
      .clk(clk), .rstn(rstn), .spi_data_out(spi_data_out), .spi_data_oe(spi_data_oe),
      .spi_select(spi_select), .spi_clk_out(spi_clk_out), .use_neg_spi_clk(use_neg_spi_clk),
      .addr_in(addr_in), .start_write(start_write), .stop_write(stop_write),
      .data_in(data_in), .data_valid(data_valid), .data_ready(data_ready), .stalled(stalled)
   );
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask
   function automatic logic [7:0] exp_nib(input int p, input logic [AB-1:0] a, input logic [7:0] b[$]);
      logic [7:0] c;
      int j;
      c = CMD;
      if (p < 8) return {7'b0001000, c[7-p]};
      if (p < 8 + NIB) return {4'b1111, 4'(a >> (AB - 4 - 4 * (p - 8)))};
      j = p - 8 - NIB;
      if (j > 2 * b.size() - 1) j = 2 * b.size() - 1;
      return {4'b1111, (j % 2 == 1) ? b[j/2][3:0] : b[j/2][7:4]};
   endfunction
   function automatic logic sclk_exp(input int c);
      return c >= 1 && c <= 36 && c % 2 == 0;
   endfunction
   task automatic tick();
      @(posedge clk);
      #2;
      cyc++;
      start_write = 1'b0;
      stop_write = 1'b0;
      if (!use_neg_spi_clk) begin
         if (spi_clk_out && !prev_clk) cap.push_back({spi_data_oe, spi_data_out});
         if (stalled) check("stall_clk", spi_clk_out, 0);
         if (cyc == rs + 1) check("resume_stall", stalled, 1);
         if (cyc == rs + 2) begin
            check("resume_run", stalled, 0);
            check("resume_hi", spi_data_out, rb[7:4]);
            check("resume_clk_low", spi_clk_out, 0);
         end
         if (cyc == rs + 3) check("resume_edge", spi_clk_out, 1);
      end
      prev_clk = spi_clk_out;
      if (wt > 0) wt--;
      data_valid = bq.size() > 0 && wt == 0;
      data_in = data_valid ? bq[0] : 8'($urandom);
      if (data_valid && data_ready) begin
         if (stalled) begin
            rs = cyc;
            rb = bq[0];
         end
         acc.push_back(cyc);
         void'(bq.pop_front());
         wt = gq.size() > 0 ? gq.pop_front() : 0;
      end
   endtask
   task automatic idle_check(input string tag);
      check({tag, "_sel"}, spi_select, 1);
      check({tag, "_clk"}, spi_clk_out, 0);
      check({tag, "_oe"}, spi_data_oe, 0);
      check({tag, "_ready"}, data_ready, 0);
      check({tag, "_stalled"}, stalled, 0);
   endtask
   task automatic begin_txn(input logic [AB-1:0] a, input logic [7:0] b[$], input int g[$]);
      bq = b;
      gq = g;
      wt = 0;
      cap = {};
      acc = {};
      rs = -10;
      addr_in = a;
      start_write = 1'b1;
      cyc = 0;
   endtask
   task automatic run_exact(input logic neg);
      logic [7:0] b[$];
      int g[$];
      b = {8'hA5, 8'h3C};
      g = {};
      use_neg_spi_clk = neg;
      begin_txn(24'h123456, b, g);
      for (int c = 1; c <= 38; c++) begin
         tick();
         check("x_sel", spi_select, 0);
         check("x_io", {spi_data_oe, spi_data_out}, exp_nib((c - 1) / 2, 24'h123456, b));
         check("x_stalled", stalled, c >= 37);
         check("x_clk", spi_clk_out, neg ? sclk_exp(c - 1) : sclk_exp(c));
         if (neg) begin
            #5;
            check("x_clk_late", spi_clk_out, sclk_exp(c));
         end
      end
      stop_write = 1'b1;
      tick();
      idle_check("x_stop");
      use_neg_spi_clk = 1'b0;
      tick();
   endtask
   task automatic run_txn(input logic [AB-1:0] a, input logic [7:0] b[$], input int g[$]);
      int need, lim;
      need = 8 + NIB + 2 * b.size();
      lim = 0;
      begin_txn(a, b, g);
      while (cap.size() < need && lim < 3000) begin
         tick();
         lim++;
         if (cyc == 40) begin
            start_write = 1'b1;
            addr_in = ~a;
         end
      end
      check("stream_len", cap.size(), need);
      repeat (3) tick();
      check("tail_stalled", stalled, 1);
      check("tail_len", cap.size(), need);
      for (int p = 0; p < cap.size() && p < need; p++) check("stream", cap[p], exp_nib(p, a, b));
      stop_write = 1'b1;
      tick();
      idle_check("stop");
   endtask
   initial begin
      logic [7:0] bb[$];
      int gg[$];
      tick();
      tick();
      idle_check("reset");
      check("reset_data", spi_data_out, 0);
      rstn = 1'b1;
      tick();
      run_exact(1'b0);
      run_exact(1'b1);
      bb = {8'hA5, 8'h3C};
      gg = {40};
      run_txn(24'hABCDEF, bb, gg);
      check("stall_seen", rs > 0, 1);
      bb = {8'h11};
      gg = {};
      begin_txn(24'($urandom), bb, gg);
      while (cyc < 20) tick();
      stop_write = 1'b1;
      tick();
      idle_check("stop20");
      bq.delete();
      repeat (2) tick();
      check("stop20_hold", spi_select, 1);
      bb = {8'h5A, 8'hC3, 8'h0F};
      gg = {0, 2};
      run_txn(24'h00F0F0, bb, gg);
      bb = {8'h77, 8'h88, 8'h99};
      gg = {};
      begin_txn(24'h654321, bb, gg);
      while (cyc < 34) tick();
      check("in_data", spi_select, 0);
      stop_write = 1'b1;
      start_write = 1'b1;
      tick();
      idle_check("stop_start");
      bq.delete();
      repeat (3) tick();
      check("no_restart", spi_select, 1);
      bb = {8'hE1};
      begin_txn(24'h0BEEF0, bb, gg);
      while (cyc < 30) tick();
      rstn = 1'b0;
      tick();
      idle_check("rst_mid");
      bq.delete();
      rstn = 1'b1;
      tick();
      for (int i = 0; i < 6; i++) begin
         int n;
         n = $urandom_range(1, 6);
         bb = {};
         gg = {};
         for (int k = 0; k < n; k++) begin
            bb.push_back(8'($urandom));
            gg.push_back($urandom_range(0, i < 3 ? 3 : 15));
         end
         run_txn(24'($urandom), bb, gg);
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
